alu_insn_decode_queue: RTL and testbench

- Registered successor to the single-output I-type ALU decoder; generalised to both OP-IMM (opcode 0010011) and OP (opcode 0110011), to XLEN 32/64, and adds illegal-encoding detection.
- Decoded results are buffered in a parametrised FIFO with valid/ready handshakes on both sides.
- Sits between fetch and the execute stage, decoupling fetch from ALU stalls.
- Also provides a flush and a saturating illegal-instruction counter.

---
 rtl/alu_insn_decode_queue.sv | 146 ++++++++++++++
 tb/tb_alu_insn_decode_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_insn_decode_queue.sv
// Registered decoder for OP-IMM / OP ALU instructions with illegal-encoding detection,
// feeding a small valid/ready FIFO toward execute, plus a saturating illegal-entry counter.
module alu_insn_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_ctrl,
  output logic             out_use_imm,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;
  // Bits above the shamt field: funct7 on RV32, insn[31:26] on RV64.
  localparam int UPW = 12 - SHW;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]     OPC_OPIMM = 7'b0010011;
  localparam logic [6:0]     OPC_OP    = 7'b0110011;
  localparam logic [UPW-1:0] UP_SRA    = {2'b01, {(UPW-2){1'b0}}};

  typedef struct packed {
    logic [3:0]      alu_ctrl;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            illegal;
  } entry_t;

  entry_t         dec;
  logic [6:0]     opcode;
  logic [2:0]     f3;
  logic [6:0]     f7;
  logic [SHW-1:0] shamt;
  logic [UPW-1:0] upper;
  logic           is_opimm;
  logic           is_op;
  logic           is_shift;
  logic           sub_sra;

  always_comb begin
    opcode   = in_insn[6:0];
    f3       = in_insn[14:12];
    f7       = in_insn[31:25];
    shamt    = in_insn[20 +: SHW];
    upper    = in_insn[31 -: UPW];
    is_opimm = (opcode == OPC_OPIMM);
    is_op    = (opcode == OPC_OP);
    is_shift = (f3[1:0] == 2'b01);
    sub_sra  = (f3[2:1] == 2'b01) |
               (in_insn[30] & ((f3 == 3'b101) | (is_op & (f3 == 3'b000))));

    dec          = '0;
    dec.alu_ctrl = {sub_sra, f3};
    dec.use_imm  = is_opimm;
    dec.rd       = in_insn[11:7];
    dec.rs1      = in_insn[19:15];
    dec.rs2      = in_insn[24:20];

    if (is_opimm) begin
      if (is_shift) dec.imm = {{(XLEN-SHW){1'b0}}, shamt};
      else          dec.imm = {{(XLEN-12){in_insn[31]}}, in_insn[31:20]};
    end

    if (is_opimm) begin
      if (f3 == 3'b001)      dec.illegal = (upper != '0);
      else if (f3 == 3'b101) dec.illegal = (upper != '0) && (upper != UP_SRA);
    end else if (is_op) begin
      if (f7 == 7'b0100000) dec.illegal = (f3 != 3'b000) && (f3 != 3'b101);
      else                  dec.illegal = (f7 != 7'b0000000);
    end else begin
      dec.illegal = 1'b1;
    end
  end

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        illegal_count <= '0;
    else if (push && dec.illegal && (illegal_count != '1)) illegal_count <= illegal_count + CNT_W'(1);
  end

  assign head         = mem[rd_ptr];
  assign out_alu_ctrl = head.alu_ctrl;
  assign out_use_imm  = head.use_imm;
  assign out_imm      = head.imm;
  assign out_rd       = head.rd;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_alu_insn_decode_queue.sv
// Randomized bench: an RV32 and an RV64 instance share stimulus and are compared
// against a queue-based model that decodes from the instruction encoding rules.
module tb_alu_insn_decode_queue;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_insn = '0;

  logic             a_in_ready, a_out_valid, a_use_imm, a_illegal;
  logic [3:0]       a_ctrl;
  logic [31:0]      a_imm;
  logic [4:0]       a_rd, a_rs1, a_rs2;
  logic [CNT_W-1:0] a_cnt;
  logic             b_in_ready, b_out_valid, b_use_imm, b_illegal;
  logic [3:0]       b_ctrl;
  logic [63:0]      b_imm;
  logic [4:0]       b_rd, b_rs1, b_rs2;
  logic [CNT_W-1:0] b_cnt;

  alu_insn_decode_queue #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_insn(in_insn), .out_valid(a_out_valid), .out_ready(out_ready), .out_alu_ctrl(a_ctrl),
    .out_use_imm(a_use_imm), .out_imm(a_imm), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_illegal(a_illegal), .illegal_count(a_cnt));

  alu_insn_decode_queue #(.XLEN(64), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_insn(in_insn), .out_valid(b_out_valid), .out_ready(out_ready), .out_alu_ctrl(b_ctrl),
    .out_use_imm(b_use_imm), .out_imm(b_imm), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_illegal(b_illegal), .illegal_count(b_cnt));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  logic [31:0] pend[$];
  int cnt32 = 0;
  int cnt64 = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic        use_imm;
    logic [63:0] imm;
    logic        ill;
  } ref_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ref_t ref_decode(input logic [31:0] insn, input int xlen);
    ref_t r;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int up, sra_up;
    logic sub;
    op = insn[6:0];
    f3 = insn[14:12];
    f7 = insn[31:25];
    r.use_imm = (op == 7'h13);
    r.imm = '0;
    r.ill = 1'b1;
    if (op == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        r.imm  = (xlen == 64) ? 64'(insn[25:20]) : 64'(insn[24:20]);
        up     = (xlen == 64) ? int'(insn[31:26]) : int'(insn[31:25]);
        sra_up = (xlen == 64) ? 'h10 : 'h20;
        r.ill  = (f3 == 3'd1) ? (up != 0) : !(up == 0 || up == sra_up);
      end else begin
        r.imm = {{52{insn[31]}}, insn[31:20]};
        r.ill = 1'b0;
      end
    end else if (op == 7'h33) begin
      r.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    end
    sub = (f3 == 3'd2 || f3 == 3'd3) || (f3 == 3'd5 && insn[30]) ||
          (op == 7'h33 && f3 == 3'd0 && insn[30]);
    r.ctrl = {sub, f3};
    return r;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] x;
    int s;
    x = $urandom;
    s = $urandom_range(0, 9);
    if (s < 4)      x[6:0] = 7'h13;
    else if (s < 8) x[6:0] = 7'h33;
    case ($urandom_range(0, 3))
      0: x[31:25] = 7'h00;
      1: x[31:25] = 7'h20;
      2: x[31:26] = 6'h10;
      default: ;
    endcase
    return x;
  endfunction

  // Called at a falling edge: checks current outputs, drives inputs, advances the model.
  task automatic step(input bit v, input bit rdy, input bit fl);
    ref_t e;
    bit do_push, do_pop;
    chk("out_valid32", a_out_valid, q.size() != 0);
    chk("out_valid64", b_out_valid, q.size() != 0);
    chk("in_ready32", a_in_ready, q.size() < DEPTH);
    chk("in_ready64", b_in_ready, q.size() < DEPTH);
    chk("ill_cnt32", a_cnt, cnt32);
    chk("ill_cnt64", b_cnt, cnt64);
    if (q.size() != 0) begin
      e = ref_decode(q[0], 32);
      chk("ctrl32", a_ctrl, e.ctrl);
      chk("use_imm32", a_use_imm, e.use_imm);
      chk("imm32", a_imm, e.imm[31:0]);
      chk("illegal32", a_illegal, e.ill);
      chk("rd32", a_rd, q[0][11:7]);
      chk("rs1_32", a_rs1, q[0][19:15]);
      chk("rs2_32", a_rs2, q[0][24:20]);
      e = ref_decode(q[0], 64);
      chk("ctrl64", b_ctrl, e.ctrl);
      chk("use_imm64", b_use_imm, e.use_imm);
      chk("imm64", b_imm, e.imm);
      chk("illegal64", b_illegal, e.ill);
      chk("rd64", b_rd, q[0][11:7]);
      chk("rs1_64", b_rs1, q[0][19:15]);
      chk("rs2_64", b_rs2, q[0][24:20]);
    end
    in_valid  = v && (pend.size() != 0);
    in_insn   = (pend.size() != 0) ? pend[0] : $urandom;
    out_ready = rdy;
    flush     = fl;
    do_push = in_valid && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() != 0) && rdy && !fl;
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (ref_decode(in_insn, 32).ill && cnt32 < 255) cnt32++;
        if (ref_decode(in_insn, 64).ill && cnt64 < 255) cnt64++;
        q.push_back(in_insn);
        void'(pend.pop_front());
      end
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0);

    // SRAI then ADDI
    pend.push_back(32'h40435293);
    pend.push_back(32'h00A30313);
    step(1, 0, 0);
    chk("srai_ctrl", a_ctrl, 4'b1101);
    chk("srai_imm", a_imm, 32'd4);
    chk("srai_rd", a_rd, 5'd5);
    chk("srai_use_imm", a_use_imm, 1'b1);
    chk("srai_ill", a_illegal, 1'b0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("addi_ctrl", a_ctrl, 4'b0000);
    chk("addi_imm", a_imm, 32'd10);
    step(0, 1, 0);

    // SUB, SLT, illegal OP
    pend.push_back(32'h40B50533);
    pend.push_back(32'h00B52533);
    pend.push_back(32'h40B54533);
    for (int i = 0; i < 8 && pend.size() != 0; i++) step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    chk("cnt_after_bad_op32", a_cnt, 8'd1);
    chk("cnt_after_bad_op64", b_cnt, 8'd1);

    // Backpressure: third instruction held until consumer drains
    repeat (3) pend.push_back(rand_insn());
    repeat (4) step(1, 0, 0);
    chk("full_in_ready", a_in_ready, 1'b0);
    for (int i = 0; i < 10 && (pend.size() != 0 || q.size() != 0); i++) step(1, 1, 0);

    // Full FIFO streaming
    repeat (14) pend.push_back(rand_insn());
    repeat (3) step(1, 0, 0);
    repeat (10) step(1, 1, 0);
    for (int i = 0; i < 10 && (pend.size() != 0 || q.size() != 0); i++) step(1, 1, 0);

    // Flush with two entries queued and a valid input presented
    repeat (3) pend.push_back(32'h0000007F);
    repeat (2) step(1, 0, 0);
    step(1, 0, 1);
    chk("flush_out_valid", a_out_valid, 1'b0);
    chk("flush_in_ready", a_in_ready, 1'b1);
    step(0, 0, 0);
    pend.delete();

    // RV64 SLLI with shamt=32
    pend.push_back(32'h02031293);
    step(1, 0, 0);
    chk("slli64_ill", b_illegal, 1'b0);
    chk("slli64_imm", b_imm, 64'd32);
    step(0, 1, 0);

    // Asynchronous reset with entries queued
    repeat (2) pend.push_back(rand_insn());
    repeat (2) step(1, 0, 0);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_in_ready", b_in_ready, 1'b1);
    chk("rst_cnt32", a_cnt, 8'd0);
    chk("rst_cnt64", b_cnt, 8'd0);
    q.delete();
    pend.delete();
    cnt32 = 0;
    cnt64 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (pend.size() < 2) pend.push_back(rand_insn());
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    pend.delete();
    step(0, 0, 1);

    // Counter saturation
    repeat (300) pend.push_back(32'h0000007F);
    for (int i = 0; i < 700 && pend.size() != 0; i++) step(1, 1, 0);
    chk("sat_drained", pend.size(), 0);
    repeat (3) step(0, 1, 0);
    chk("sat_cnt32", a_cnt, 8'd255);
    chk("sat_cnt64", b_cnt, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
